// File: rtl/load_store_unit_pkg.sv
// Shared types for the RV32I load/store unit: FSM states and funct3 encodings.
// The funct3 values match the select encoding of the downstream extender.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response bus from execute and the data-memory bus of the load/store unit.
// The "master" modport is the side that issues requests on each bus.
interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [2:0]  rsp_funct3;
    logic        rsp_misaligned;
    logic        rsp_timeout;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_funct3, rsp_misaligned, rsp_timeout
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_funct3, rsp_misaligned, rsp_timeout
    );
endinterface

interface lsu_mem_if;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane steering: store data replication, byte enables, illegal-access
// decode for an incoming request, and right-alignment of returned load data.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic        illegal_o,
    input  logic [1:0]  rd_offset_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] rdata_o
);

    always_comb begin
        wdata_o   = '0;
        be_o      = '0;
        illegal_o = 1'b0;
        if (we_i) begin
            case (funct3_i)
                SB: begin
                    wdata_o = {4{wdata_i[7:0]}};
                    be_o    = 4'b0001 << offset_i;
                end
                SH: begin
                    wdata_o   = {2{wdata_i[15:0]}};
                    be_o      = 4'b0011 << offset_i;
                    illegal_o = offset_i[0];
                end
                SW: begin
                    wdata_o   = wdata_i;
                    be_o      = 4'b1111;
                    illegal_o = |offset_i;
                end
                default: illegal_o = 1'b1;
            endcase
        end else begin
            case (funct3_i)
                LB, LBU:  illegal_o = 1'b0;
                LH, LHU:  illegal_o = offset_i[0];
                LW:       illegal_o = |offset_i;
                default:  illegal_o = 1'b1;
            endcase
        end
    end

    // Upper bytes fill with zero; the extender applies sign extension afterwards.
    assign rdata_o = rdata_i >> {rd_offset_i, 3'b000};

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: accepts one load/store at a time, drives the
// valid/ready memory bus and returns right-aligned load data with its funct3.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic      clk,
    input  logic      rst_n,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);

    localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);

    lsu_state_e  state_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic        expired;

    logic        req_ready_q;
    logic        mem_valid_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_be_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic [2:0]  rsp_funct3_q;
    logic        rsp_misaligned_q;
    logic        rsp_timeout_q;

    logic [31:0] lane_wdata;
    logic [3:0]  lane_be;
    logic        lane_illegal;
    logic [31:0] lane_rdata;

    lsu_align u_align (
        .we_i        (req.req_we),
        .funct3_i    (req.req_funct3),
        .offset_i    (req.req_addr[1:0]),
        .wdata_i     (req.req_wdata),
        .wdata_o     (lane_wdata),
        .be_o        (lane_be),
        .illegal_o   (lane_illegal),
        .rd_offset_i (offset_q),
        .rdata_i     (mem.mem_rdata),
        .rdata_o     (lane_rdata)
    );

    // Expiry is the cycle in which the counter would reach the limit.
    assign cnt_d   = cnt_q + 8'd1;
    assign expired = (cnt_d == TimeoutLimit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            we_q             <= 1'b0;
            funct3_q         <= '0;
            offset_q         <= '0;
            cnt_q            <= '0;
            req_ready_q      <= 1'b1;
            mem_valid_q      <= 1'b0;
            mem_we_q         <= 1'b0;
            mem_addr_q       <= '0;
            mem_wdata_q      <= '0;
            mem_be_q         <= '0;
            rsp_valid_q      <= 1'b0;
            rsp_rdata_q      <= '0;
            rsp_funct3_q     <= '0;
            rsp_misaligned_q <= 1'b0;
            rsp_timeout_q    <= 1'b0;
        end else begin
            rsp_valid_q      <= 1'b0;
            rsp_rdata_q      <= '0;
            rsp_funct3_q     <= '0;
            rsp_misaligned_q <= 1'b0;
            rsp_timeout_q    <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (req.req_valid) begin
                        we_q        <= req.req_we;
                        funct3_q    <= req.req_funct3;
                        offset_q    <= req.req_addr[1:0];
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        if (lane_illegal) begin
                            state_q          <= RESP;
                            rsp_valid_q      <= 1'b1;
                            rsp_funct3_q     <= req.req_funct3;
                            rsp_misaligned_q <= 1'b1;
                        end else begin
                            state_q     <= ADDR;
                            mem_valid_q <= 1'b1;
                            mem_we_q    <= req.req_we;
                            mem_addr_q  <= {req.req_addr[31:2], 2'b00};
                            mem_wdata_q <= lane_wdata;
                            mem_be_q    <= lane_be;
                        end
                    end
                end

                ADDR: begin
                    cnt_q <= cnt_d;
                    if (mem.mem_ready || expired) begin
                        mem_valid_q <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        mem_be_q    <= '0;
                    end
                    // A handshake in the expiry cycle takes priority over the timeout.
                    if (mem.mem_ready) begin
                        if (we_q) begin
                            state_q      <= RESP;
                            rsp_valid_q  <= 1'b1;
                            rsp_funct3_q <= funct3_q;
                        end else begin
                            state_q <= WAIT;
                        end
                    end else if (expired) begin
                        state_q       <= RESP;
                        rsp_valid_q   <= 1'b1;
                        rsp_funct3_q  <= funct3_q;
                        rsp_timeout_q <= 1'b1;
                    end
                end

                WAIT: begin
                    cnt_q <= cnt_d;
                    if (mem.mem_rvalid) begin
                        state_q      <= RESP;
                        rsp_valid_q  <= 1'b1;
                        rsp_rdata_q  <= lane_rdata;
                        rsp_funct3_q <= funct3_q;
                    end else if (expired) begin
                        state_q       <= RESP;
                        rsp_valid_q   <= 1'b1;
                        rsp_funct3_q  <= funct3_q;
                        rsp_timeout_q <= 1'b1;
                    end
                end

                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end

                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req.req_ready      = req_ready_q;
    assign req.rsp_valid      = rsp_valid_q;
    assign req.rsp_rdata      = rsp_rdata_q;
    assign req.rsp_funct3     = rsp_funct3_q;
    assign req.rsp_misaligned = rsp_misaligned_q;
    assign req.rsp_timeout    = rsp_timeout_q;

    assign mem.mem_valid = mem_valid_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_be    = mem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: responses are queued when a request is
// driven and checked by a monitor when rsp_valid appears.
module tb_load_store_unit;

    localparam int Timeout = 4;

    typedef struct {
        logic [31:0] rdata;
        logic [2:0]  funct3;
        logic        misaligned;
        logic        timedOut;
    } rsp_t;

    logic clk;
    logic rst_n;
    int   testsRun    = 0;
    int   testsFailed = 0;
    rsp_t expQ[$];

    lsu_req_if reqIf ();
    lsu_mem_if memIf ();

    load_store_unit #(.TIMEOUT_CYCLES(Timeout)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (reqIf),
        .mem   (memIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic modelIllegal(input logic we, input logic [2:0] f3, input logic [1:0] off);
        if (we)
            return !(f3 == 3'b000 || (f3 == 3'b001 && !off[0]) || (f3 == 3'b010 && off == 2'b00));
        return !(f3 == 3'b000 || f3 == 3'b100 || ((f3 == 3'b001 || f3 == 3'b101) && !off[0])
                 || (f3 == 3'b010 && off == 2'b00));
    endfunction

    function automatic int accessSize(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [3:0] modelBe(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be = '0;
        int size = accessSize(f3);
        if (!we) return 4'b0000;
        for (int b = 0; b < 4; b++) be[b] = (b >= int'(off)) && (b < int'(off) + size);
        return be;
    endfunction

    function automatic logic [31:0] modelWdata(input logic we, input logic [2:0] f3, input logic [31:0] wdata);
        logic [31:0] res = '0;
        int size = accessSize(f3);
        if (!we) return 32'h0;
        for (int b = 0; b < 4; b++) res[8*b +: 8] = wdata[8*(b % size) +: 8];
        return res;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [1:0] off);
        logic [31:0] res = '0;
        for (int b = 0; b < 4; b++)
            if (b + int'(off) < 4) res[8*b +: 8] = word[8*(b + int'(off)) +: 8];
        return res;
    endfunction

    // Monitor: every response must match the oldest queued expectation.
    always @(negedge clk) begin
        rsp_t e;
        if (rst_n && reqIf.rsp_valid) begin
            checkOutput("rsp_expected", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("rsp_rdata", reqIf.rsp_rdata, e.rdata);
                checkOutput("rsp_funct3", 32'(reqIf.rsp_funct3), 32'(e.funct3));
                checkOutput("rsp_misaligned", 32'(reqIf.rsp_misaligned), 32'(e.misaligned));
                checkOutput("rsp_timeout", 32'(reqIf.rsp_timeout), 32'(e.timedOut));
            end
        end
    end

    task automatic checkResetState(input string pfx);
        checkOutput({pfx, "_req_ready"}, 32'(reqIf.req_ready), 32'd1);
        checkOutput({pfx, "_rsp_valid"}, 32'(reqIf.rsp_valid), 32'd0);
        checkOutput({pfx, "_rsp_rdata"}, reqIf.rsp_rdata, 32'd0);
        checkOutput({pfx, "_rsp_funct3"}, 32'(reqIf.rsp_funct3), 32'd0);
        checkOutput({pfx, "_rsp_misaligned"}, 32'(reqIf.rsp_misaligned), 32'd0);
        checkOutput({pfx, "_rsp_timeout"}, 32'(reqIf.rsp_timeout), 32'd0);
        checkOutput({pfx, "_mem_valid"}, 32'(memIf.mem_valid), 32'd0);
        checkOutput({pfx, "_mem_we"}, 32'(memIf.mem_we), 32'd0);
        checkOutput({pfx, "_mem_addr"}, memIf.mem_addr, 32'd0);
        checkOutput({pfx, "_mem_wdata"}, memIf.mem_wdata, 32'd0);
        checkOutput({pfx, "_mem_be"}, 32'(memIf.mem_be), 32'd0);
    endtask

    // Drives one request from a negedge in IDLE and plays the memory side.
    // readyDelay/rvalidDelay count idle cycles before mem_ready/mem_rvalid.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int readyDelay, input int rvalidDelay,
                                 input logic [31:0] rdata, input bit lateRvalid);
        rsp_t e;
        logic ill;
        bit   expTo;
        bit   inAddr;
        bit   rv;
        int   addrCyc, waitCyc, expLat;
        ill     = modelIllegal(we, f3, addr[1:0]);
        addrCyc = readyDelay + 1;
        waitCyc = we ? 0 : rvalidDelay + 1;
        expTo   = !ill && (addrCyc + waitCyc > Timeout);
        expLat  = ill ? 1 : (expTo ? Timeout + 1 : addrCyc + waitCyc + 1);
        e.rdata      = (!ill && !expTo && !we) ? modelLoad(rdata, addr[1:0]) : 32'h0;
        e.funct3     = f3;
        e.misaligned = ill;
        e.timedOut   = expTo;

        checkOutput("req_ready_idle", 32'(reqIf.req_ready), 32'd1);
        reqIf.req_valid  = 1'b1;
        reqIf.req_we     = we;
        reqIf.req_funct3 = f3;
        reqIf.req_addr   = addr;
        reqIf.req_wdata  = wdata;
        expQ.push_back(e);
        @(negedge clk);
        reqIf.req_valid  = 1'b0;
        reqIf.req_we     = $urandom_range(0, 1);
        reqIf.req_funct3 = 3'($urandom);
        reqIf.req_addr   = $urandom;
        reqIf.req_wdata  = $urandom;

        for (int c = 1; c <= expLat + 3; c++) begin
            inAddr = !ill && (c <= addrCyc) && (c <= Timeout);
            checkOutput("mem_valid", 32'(memIf.mem_valid), 32'(inAddr));
            checkOutput("rsp_valid_timing", 32'(reqIf.rsp_valid), 32'(c == expLat));
            checkOutput("req_ready_busy", 32'(reqIf.req_ready), 32'(c > expLat));
            if (inAddr) begin
                checkOutput("mem_addr", memIf.mem_addr, {addr[31:2], 2'b00});
                checkOutput("mem_we", 32'(memIf.mem_we), 32'(we));
                checkOutput("mem_be", 32'(memIf.mem_be), 32'(modelBe(we, f3, addr[1:0])));
                checkOutput("mem_wdata", memIf.mem_wdata, modelWdata(we, f3, wdata));
            end
            rv = (!we && !ill && !expTo && c == addrCyc + waitCyc) || (lateRvalid && c == expLat + 1);
            memIf.mem_ready  = inAddr && (c == addrCyc);
            memIf.mem_rvalid = rv;
            memIf.mem_rdata  = rv ? rdata : $urandom;
            @(negedge clk);
        end
        memIf.mem_ready  = 1'b0;
        memIf.mem_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n            = 1'b0;
        reqIf.req_valid  = 1'b0;
        reqIf.req_we     = 1'b0;
        reqIf.req_funct3 = 3'b000;
        reqIf.req_addr   = 32'h0;
        reqIf.req_wdata  = 32'h0;
        memIf.mem_ready  = 1'b0;
        memIf.mem_rvalid = 1'b0;
        memIf.mem_rdata  = 32'h0;
        repeat (2) @(negedge clk);
        checkResetState("reset");
        rst_n = 1'b1;
        @(negedge clk);
        checkResetState("post_reset");

        //             we    f3      addr          wdata         rdy  rv  rdata         late
        applyStimulus(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0,   0,  32'h0,         1'b0);
        applyStimulus(1'b0, 3'b101, 32'h0000_2002, 32'h0,         0,   0,  32'hBEEF_1234, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h0000_3001, 32'h0,         0,   0,  32'h1111_1111, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h0000_3000, 32'h0,         100, 0,  32'hCAFE_F00D, 1'b1);
        applyStimulus(1'b0, 3'b010, 32'h0000_3004, 32'h0,         0,   2,  32'h8765_4321, 1'b0);
        applyStimulus(1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 1,   0,  32'h0,         1'b0);
        applyStimulus(1'b1, 3'b010, 32'h0000_0200, 32'hDEAD_BEEF, 3,   0,  32'h0,         1'b0);
        applyStimulus(1'b1, 3'b010, 32'h0000_0204, 32'h0BAD_CAFE, 4,   0,  32'h0,         1'b0);
        applyStimulus(1'b0, 3'b000, 32'h0000_0013, 32'h0,         1,   0,  32'h5A00_0000, 1'b0);
        applyStimulus(1'b0, 3'b001, 32'h0000_0016, 32'h0,         0,   1,  32'h7FFE_0000, 1'b0);
        applyStimulus(1'b1, 3'b001, 32'h0000_0101, 32'h0000_5555, 0,   0,  32'h0,         1'b0);
        applyStimulus(1'b1, 3'b011, 32'h0000_0100, 32'h0000_5555, 0,   0,  32'h0,         1'b0);
        applyStimulus(1'b0, 3'b110, 32'h0000_0100, 32'h0,         0,   0,  32'h0,         1'b0);

        // Reset while the load sits in WAIT; that access must never respond.
        reqIf.req_valid  = 1'b1;
        reqIf.req_we     = 1'b0;
        reqIf.req_funct3 = 3'b000;
        reqIf.req_addr   = 32'h0000_5000;
        @(negedge clk);
        reqIf.req_valid  = 1'b0;
        memIf.mem_ready  = 1'b1;
        @(negedge clk);
        memIf.mem_ready  = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkResetState("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 3'b000, 32'h0000_4000, 32'h0, 0, 0, 32'h0000_00C3, 1'b0);

        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
